// File: rtl/mem_xfer88.sv
// rtl/mem_xfer88.sv - byte-serial segment:offset memory transfer engine (READ/WRITE/PUSH/POP)
// Optional feature macro: SEG_WRAP_EN (multi-byte accesses wrap inside the 64 KiB segment).
// Without SEG_WRAP_EN the per-byte offset carries into the linear address.
module mem_xfer88 #(
  parameter int MAXB = 4,
  parameter int LW   = $clog2(MAXB + 1)
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              locked_i,
  input  logic              req_i,
  input  logic [1:0]        op_i,
  input  logic [LW-1:0]     len_i,
  input  logic [15:0]       seg_i,
  input  logic [15:0]       off_i,
  input  logic [15:0]       sp_in_i,
  input  logic [8*MAXB-1:0] wdata_i,
  output logic [8*MAXB-1:0] rdata_o,
  output logic [15:0]       sp_out_o,
  output logic              sp_we_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [19:0]       address_o,
  input  logic [7:0]        bus_i,
  output logic [7:0]        data_o,
  output logic              wreq_o
);

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_PUSH  = 2'd2;
  localparam logic [1:0] OP_POP   = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_FIN} state_t;

  state_t            state_q;
  logic [1:0]        op_q;
  logic [LW-1:0]     len_q;
  logic [LW-1:0]     idx_q;
  logic [15:0]       seg_q;
  logic [15:0]       base_q;
  logic [15:0]       sp_nxt_q;
  logic [8*MAXB-1:0] wdata_q;
  logic [8*MAXB-1:0] rdata_q;
  logic [15:0]       sp_out_q;
  logic              sp_we_q;
  logic              busy_q;
  logic              done_q;
  logic [19:0]       address_q;
  logic [7:0]        data_q;
  logic              wreq_q;

  logic [LW-1:0]     len_d;
  logic [LW-1:0]     idx_d;
  logic [15:0]       base_d;
  logic [15:0]       sp_nxt_d;

  // Linear address of byte i of an access starting at seg:b.
  function automatic logic [19:0] lin_addr(input logic [15:0] s, input logic [15:0] b,
                                           input logic [LW-1:0] i);
`ifdef SEG_WRAP_EN
    logic [15:0] e;
    e = b + 16'(i);
    return {s, 4'h0} + {4'h0, e};
`else
    logic [16:0] e;
    e = {1'b0, b} + 17'(i);
    return {s, 4'h0} + {3'h0, e};
`endif
  endfunction

  // Request decode: clamp length, pick base offset and the SP value reported at completion.
  always_comb begin
    len_d    = (len_i > LW'(MAXB)) ? LW'(MAXB) : len_i;
    idx_d    = idx_q + LW'(1);
    base_d   = off_i;
    sp_nxt_d = sp_in_i;
    if (op_i == OP_PUSH) begin
      base_d   = sp_in_i - 16'(len_d);
      sp_nxt_d = sp_in_i - 16'(len_d);
    end else if (op_i == OP_POP) begin
      base_d   = sp_in_i;
      sp_nxt_d = sp_in_i + 16'(len_d);
    end
  end

  // Transfer FSM with registered outputs; locked_i low freezes everything.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      op_q      <= OP_READ;
      len_q     <= '0;
      idx_q     <= '0;
      seg_q     <= '0;
      base_q    <= '0;
      sp_nxt_q  <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      sp_out_q  <= '0;
      sp_we_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      address_q <= '0;
      data_q    <= '0;
      wreq_q    <= 1'b0;
    end else if (locked_i) begin
      case (state_q)
        S_IDLE: begin
          if (req_i) begin
            op_q     <= op_i;
            len_q    <= len_d;
            seg_q    <= seg_i;
            base_q   <= base_d;
            sp_nxt_q <= sp_nxt_d;
            wdata_q  <= wdata_i;
            rdata_q  <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b1;
            if (len_d == '0) begin
              // Zero-length: no bus cycle, but stack ops still report SP.
              state_q <= S_FIN;
              done_q  <= 1'b1;
              if (op_i[1]) begin
                sp_we_q  <= 1'b1;
                sp_out_q <= sp_in_i;
              end
            end else begin
              state_q   <= S_XFER;
              address_q <= lin_addr(seg_i, base_d, '0);
              data_q    <= wdata_i[7:0];
              wreq_q    <= (op_i == OP_WRITE) || (op_i == OP_PUSH);
            end
          end
        end
        S_XFER: begin
          if ((op_q == OP_READ) || (op_q == OP_POP)) begin
            rdata_q[{idx_q, 3'b000} +: 8] <= bus_i;
          end
          if (idx_q == len_q - LW'(1)) begin
            state_q <= S_FIN;
            wreq_q  <= 1'b0;
            done_q  <= 1'b1;
            if (op_q[1]) begin
              sp_we_q  <= 1'b1;
              sp_out_q <= sp_nxt_q;
            end
          end else begin
            idx_q     <= idx_d;
            address_q <= lin_addr(seg_q, base_q, idx_d);
            data_q    <= wdata_q[{idx_d, 3'b000} +: 8];
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          sp_we_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          wreq_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rdata_o   = rdata_q;
  assign sp_out_o  = sp_out_q;
  assign sp_we_o   = sp_we_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign address_o = address_q;
  assign data_o    = data_q;
  assign wreq_o    = wreq_q;

endmodule

// File: tb/tb_mem_xfer88.sv
// tb/tb_mem_xfer88.sv - directed self-checking bench for mem_xfer88
module tb_mem_xfer88;

  localparam int MAXB = 4;
  localparam int LW   = 3;

  logic              clock = 1'b0;
  logic              reset;
  logic              locked;
  logic              req;
  logic [1:0]        op;
  logic [LW-1:0]     len;
  logic [15:0]       seg;
  logic [15:0]       off;
  logic [15:0]       sp_in;
  logic [8*MAXB-1:0] wdata;
  logic [8*MAXB-1:0] rdata;
  logic [15:0]       sp_out;
  logic              sp_we;
  logic              busy;
  logic              done;
  logic [19:0]       address;
  logic [7:0]        bus;
  logic [7:0]        data;
  logic              wreq;

  logic [7:0]  mem [0:1048575];
  int          wr_cnt = 0;
  logic [19:0] last_wa = 20'hxxxxx;

  int checks = 0;
  int errors = 0;

  mem_xfer88 #(.MAXB(MAXB)) dut (
    .clock_i(clock), .reset_i(reset), .locked_i(locked), .req_i(req),
    .op_i(op), .len_i(len), .seg_i(seg), .off_i(off), .sp_in_i(sp_in),
    .wdata_i(wdata), .rdata_o(rdata), .sp_out_o(sp_out), .sp_we_o(sp_we),
    .busy_o(busy), .done_o(done), .address_o(address), .bus_i(bus),
    .data_o(data), .wreq_o(wreq)
  );

  always #5 clock = ~clock;

  assign bus = mem[address];

  always @(posedge clock) begin
    if (wreq) begin
      mem[address] <= data;
      if (last_wa !== address) begin
        wr_cnt  <= wr_cnt + 1;
        last_wa <= address;
      end
    end
  end

  task automatic start(input logic [1:0] o, input logic [LW-1:0] l, input logic [15:0] s,
                       input logic [15:0] of, input logic [15:0] sp, input logic [31:0] wd);
    op = o; len = l; seg = s; off = of; sp_in = sp; wdata = wd; req = 1'b1;
    @(negedge clock);
    req = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({busy, done, sp_we, wreq} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0000", {busy, done, sp_we, wreq});
    end
    checks++;
    if ({rdata, sp_out, address, data} !== '0) begin
      errors++; $display("FAIL reset_data: got %h %h %h %h expected zeros", rdata, sp_out, address, data);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_read;
    logic [19:0] a2;
    logic [31:0] rexp;
`ifdef SEG_WRAP_EN
    a2 = 20'hF0000; rexp = 32'h0000ABCD;
`else
    a2 = 20'h00000; rexp = 32'h00005ACD;
`endif
    mem[20'hFFFFF] = 8'hCD; mem[20'hF0000] = 8'hAB; mem[20'h00000] = 8'h5A;
    start(2'd0, 3'd2, 16'hF000, 16'hFFFF, 16'h0000, 32'h0);
    checks++;
    if (address !== 20'hFFFFF || wreq !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL read_b0: got addr %h wreq %b busy %b expected FFFFF 0 1", address, wreq, busy);
    end
    @(negedge clock);
    checks++;
    if (address !== a2 || done !== 1'b0) begin
      errors++; $display("FAIL read_b1: got addr %h done %b expected %h 0", address, done, a2);
    end
    @(negedge clock);
    checks++;
    if (done !== 1'b1 || rdata !== rexp || sp_we !== 1'b0) begin
      errors++; $display("FAIL read_done: got done %b rdata %h sp_we %b expected 1 %h 0", done, rdata, sp_we, rexp);
    end
    @(negedge clock);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || rdata !== rexp) begin
      errors++; $display("FAIL read_idle: got done %b busy %b rdata %h expected 0 0 %h", done, busy, rdata, rexp);
    end
  endtask

  task automatic test_push;
    logic [19:0] ea [4];
    logic [7:0]  ed [4];
    ea[0] = 20'h1FFFE; ea[1] = 20'h1FFFF;
`ifdef SEG_WRAP_EN
    ea[2] = 20'h10000; ea[3] = 20'h10001;
`else
    ea[2] = 20'h20000; ea[3] = 20'h20001;
`endif
    ed[0] = 8'h44; ed[1] = 8'h33; ed[2] = 8'h22; ed[3] = 8'h11;
    start(2'd2, 3'd4, 16'h1000, 16'h0000, 16'h0002, 32'h11223344);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (address !== ea[i] || data !== ed[i] || wreq !== 1'b1 || done !== 1'b0) begin
        errors++; $display("FAIL push_b%0d: got %h %h wreq %b done %b expected %h %h 1 0",
                           i, address, data, wreq, done, ea[i], ed[i]);
      end
      @(negedge clock);
    end
    checks++;
    if (done !== 1'b1 || sp_we !== 1'b1 || sp_out !== 16'hFFFE || wreq !== 1'b0) begin
      errors++; $display("FAIL push_done: got done %b sp_we %b sp_out %h wreq %b expected 1 1 FFFE 0",
                         done, sp_we, sp_out, wreq);
    end
    @(negedge clock);
    checks++;
    if (sp_we !== 1'b0 || busy !== 1'b0 || mem[ea[2]] !== 8'h22) begin
      errors++; $display("FAIL push_end: got sp_we %b busy %b mem %h expected 0 0 22", sp_we, busy, mem[ea[2]]);
    end
  endtask

  task automatic test_pop;
    int pulses = 0;
    mem[20'h20100] = 8'h34; mem[20'h20101] = 8'h12;
    start(2'd3, 3'd2, 16'h2000, 16'h0000, 16'h0100, 32'h0);
    for (int c = 1; c <= 5; c++) begin
      if (sp_we === 1'b1) pulses++;
      if (c == 3) begin
        checks++;
        if (done !== 1'b1 || rdata !== 32'h00001234 || sp_out !== 16'h0102) begin
          errors++; $display("FAIL pop_done: got done %b rdata %h sp_out %h expected 1 00001234 0102",
                             done, rdata, sp_out);
        end
      end
      @(negedge clock);
    end
    checks++;
    if (pulses !== 1) begin
      errors++; $display("FAIL pop_spwe: got %0d pulses expected 1", pulses);
    end
  endtask

  task automatic test_write_locked;
    int w0;
    w0 = wr_cnt;
    start(2'd1, 3'd3, 16'h3000, 16'h0010, 16'h0000, 32'h00AABBCC);
    @(negedge clock);
    locked = 1'b0;
    @(negedge clock);
    checks++;
    if (address !== 20'h30011 || data !== 8'hBB || wreq !== 1'b1) begin
      errors++; $display("FAIL lock_hold: got %h %h wreq %b expected 30011 BB 1", address, data, wreq);
    end
    @(negedge clock);
    locked = 1'b1;
    @(negedge clock);
    checks++;
    if (address !== 20'h30012 || data !== 8'hAA || done !== 1'b0) begin
      errors++; $display("FAIL lock_b2: got %h %h done %b expected 30012 AA 0", address, data, done);
    end
    @(negedge clock);
    checks++;
    if (done !== 1'b1 || sp_we !== 1'b0 || sp_out !== 16'h0102) begin
      errors++; $display("FAIL lock_done: got done %b sp_we %b sp_out %h expected 1 0 0102", done, sp_we, sp_out);
    end
    @(negedge clock);
    checks++;
    if (wr_cnt - w0 !== 3 || mem[20'h30010] !== 8'hCC || mem[20'h30011] !== 8'hBB || mem[20'h30012] !== 8'hAA) begin
      errors++; $display("FAIL lock_mem: got %0d writes %h %h %h expected 3 CC BB AA",
                         wr_cnt - w0, mem[20'h30010], mem[20'h30011], mem[20'h30012]);
    end
  endtask

  task automatic test_clamp;
    int w0;
    w0 = wr_cnt;
    start(2'd1, 3'd7, 16'h0000, 16'h0100, 16'h0000, 32'h44332211);
    repeat (4) @(negedge clock);
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL clamp_done: got done %b expected 1", done);
    end
    @(negedge clock);
    checks++;
    if (wr_cnt - w0 !== 4 || mem[20'h00103] !== 8'h44 || busy !== 1'b0) begin
      errors++; $display("FAIL clamp_mem: got %0d writes last %h busy %b expected 4 44 0",
                         wr_cnt - w0, mem[20'h00103], busy);
    end
  endtask

  task automatic test_reset_mid;
    int w0;
    int seen = 0;
    for (int i = 0; i < 4; i++) mem[20'h40000 + i] = 8'hEE;
    w0 = wr_cnt;
    start(2'd2, 3'd4, 16'h4000, 16'h0000, 16'h0004, 32'h11223344);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if (wreq !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid: got wreq %b busy %b expected 0 0", wreq, busy);
    end
    for (int c = 0; c < 5; c++) begin
      if (done === 1'b1 || sp_we === 1'b1) seen++;
      @(negedge clock);
    end
    checks++;
    if (seen !== 0 || wr_cnt - w0 !== 2 || mem[20'h40002] !== 8'hEE || mem[20'h40003] !== 8'hEE) begin
      errors++; $display("FAIL rst_abort: got strobes %0d writes %0d mem %h %h expected 0 2 EE EE",
                         seen, wr_cnt - w0, mem[20'h40002], mem[20'h40003]);
    end
  endtask

  task automatic test_pop_zero;
    start(2'd3, 3'd0, 16'h5000, 16'h0000, 16'h1234, 32'h0);
    checks++;
    if (done !== 1'b1 || sp_we !== 1'b1 || sp_out !== 16'h1234 || wreq !== 1'b0 || address !== 20'h0) begin
      errors++; $display("FAIL pop0_done: got done %b sp_we %b sp_out %h wreq %b addr %h expected 1 1 1234 0 00000",
                         done, sp_we, sp_out, wreq, address);
    end
    op = 2'd0; len = 3'd2; seg = 16'h6000; off = 16'h0000; req = 1'b1;
    @(negedge clock);
    req = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sp_we !== 1'b0) begin
      errors++; $display("FAIL pop0_end: got busy %b done %b sp_we %b expected 0 0 0", busy, done, sp_we);
    end
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || address !== 20'h0) begin
      errors++; $display("FAIL pop0_ignore: got busy %b addr %h expected 0 00000", busy, address);
    end
  endtask

  initial begin
    for (int i = 0; i < 1048576; i++) mem[i] = 8'h00;
    reset = 1'b1; locked = 1'b1; req = 1'b0; op = 2'd0; len = '0;
    seg = '0; off = '0; sp_in = '0; wdata = '0;
    @(negedge clock);
    test_reset;
    test_read;
    test_push;
    test_pop;
    test_write_locked;
    test_clamp;
    test_reset_mid;
    test_pop_zero;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
